// File: rtl/game_tick_sequencer.sv
// game_tick_sequencer
// Avalon-MM master that programs the interval timer peripheral (16-bit
// register map) and services its timeout interrupt. Game logic gets a clean
// one-cycle tick per timeout without any CPU involvement.
//
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   start             pulse: latch period and start timer (IDLE only)
//   stop              pulse: stop timer and clear pending timeout (any state)
//   period_in         timer reload value, 0 selects DEFAULT_PERIOD
//   timer_irq         level timeout interrupt from the timer
//   avm_waitrequest   slave stall, holds the current write
//   avm_address       timer register halfword index
//   avm_chipselect    write cycle active
//   avm_write_n       active-low write strobe
//   avm_writedata     write data
//   tick              one-cycle pulse per serviced timeout
//   tick_count        ticks since last accepted start, wraps
//   running           timer started and being serviced
//   busy              sequencer not idle
module game_tick_sequencer #(
    parameter logic [31:0] DEFAULT_PERIOD = 32'd49999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] period_in,
    input  logic        timer_irq,
    input  logic        avm_waitrequest,
    output logic [3:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [15:0] avm_writedata,
    output logic        tick,
    output logic [15:0] tick_count,
    output logic        running,
    output logic        busy
);

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 16;

    localparam logic [ADDR_W-1:0] REG_STATUS  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] REG_CONTROL = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] REG_PERIOD0 = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] REG_PERIOD1 = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] REG_PERIOD2 = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] REG_PERIOD3 = ADDR_W'(5);

    // control register bits {STOP,START,CONT,ITO}
    localparam logic [DATA_W-1:0] CTRL_RUN  = DATA_W'(16'h0007);
    localparam logic [DATA_W-1:0] CTRL_STOP = DATA_W'(16'h0008);

    typedef enum logic [3:0] {
        IDLE,
        WR_P0,
        WR_P1,
        WR_P2,
        WR_P3,
        WR_CTRL,
        RUN,
        CLR,
        CLR_WAIT,
        WR_STOP,
        WR_ACK
    } state_t;

    typedef struct packed {
        logic              cs;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } bus_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] period_q;
    logic [31:0] period_nxt;
    logic        stop_pending;
    logic        stop_req;
    logic        wr_done;
    logic        start_ok;
    logic        clr_done;
    bus_t        bus_nxt;

    // Bus cycle driven while sitting in a given state
    function automatic bus_t decode(input state_t s, input logic [31:0] p);
        bus_t b;
        b.cs   = 1'b0;
        b.addr = '0;
        b.data = '0;
        case (s)
            WR_P0:   begin b.cs = 1'b1; b.addr = REG_PERIOD0; b.data = p[15:0];  end
            WR_P1:   begin b.cs = 1'b1; b.addr = REG_PERIOD1; b.data = p[31:16]; end
            WR_P2:   begin b.cs = 1'b1; b.addr = REG_PERIOD2; end
            WR_P3:   begin b.cs = 1'b1; b.addr = REG_PERIOD3; end
            WR_CTRL: begin b.cs = 1'b1; b.addr = REG_CONTROL; b.data = CTRL_RUN;  end
            CLR:     begin b.cs = 1'b1; b.addr = REG_STATUS;  end
            WR_STOP: begin b.cs = 1'b1; b.addr = REG_CONTROL; b.data = CTRL_STOP; end
            WR_ACK:  begin b.cs = 1'b1; b.addr = REG_STATUS;  end
            default: ;
        endcase
        return b;
    endfunction

    function automatic logic is_write(input state_t s);
        return (s == WR_P0) || (s == WR_P1) || (s == WR_P2) || (s == WR_P3) ||
               (s == WR_CTRL) || (s == CLR) || (s == WR_STOP) || (s == WR_ACK);
    endfunction

    // Next-state and latched-period selection
    always_comb begin
        state_nxt  = state;
        period_nxt = period_q;
        stop_req   = stop_pending | stop;
        wr_done    = is_write(state) && !avm_waitrequest;
        start_ok   = (state == IDLE) && start && !stop;
        clr_done   = (state == CLR) && !avm_waitrequest;

        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt  = WR_P0;
                    period_nxt = (period_in == 32'd0) ? DEFAULT_PERIOD : period_in;
                end
            end
            WR_P0:   if (wr_done) state_nxt = stop_req ? WR_STOP : WR_P1;
            WR_P1:   if (wr_done) state_nxt = stop_req ? WR_STOP : WR_P2;
            WR_P2:   if (wr_done) state_nxt = stop_req ? WR_STOP : WR_P3;
            WR_P3:   if (wr_done) state_nxt = stop_req ? WR_STOP : WR_CTRL;
            WR_CTRL: if (wr_done) state_nxt = stop_req ? WR_STOP : RUN;
            RUN: begin
                if (stop_req)       state_nxt = WR_STOP;
                else if (timer_irq) state_nxt = CLR;
            end
            CLR:      if (wr_done) state_nxt = stop_req ? WR_STOP : CLR_WAIT;
            // irq drops one cycle after the status write; wait it out
            CLR_WAIT: state_nxt = stop_req ? WR_STOP : RUN;
            WR_STOP:  if (wr_done) state_nxt = WR_ACK;
            WR_ACK:   if (wr_done) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase

        bus_nxt = decode(state_nxt, period_nxt);
    end

    // State, bookkeeping and registered outputs (decoded from next state so
    // each output reflects the state it is registered alongside)
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            period_q       <= '0;
            stop_pending   <= 1'b0;
            tick           <= 1'b0;
            tick_count     <= '0;
            running        <= 1'b0;
            busy           <= 1'b0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_address    <= '0;
            avm_writedata  <= '0;
        end else begin
            state    <= state_nxt;
            period_q <= period_nxt;
            tick     <= clr_done;

            if (clr_done) begin
                tick_count <= tick_count + DATA_W'(1);
            end else if (start_ok) begin
                tick_count <= '0;
            end

            if (state_nxt == WR_ACK || state_nxt == IDLE) begin
                stop_pending <= 1'b0;
            end else if (stop && state != IDLE) begin
                stop_pending <= 1'b1;
            end

            running        <= (state_nxt == RUN) || (state_nxt == CLR) ||
                              (state_nxt == CLR_WAIT);
            busy           <= (state_nxt != IDLE);
            avm_chipselect <= bus_nxt.cs;
            avm_write_n    <= ~bus_nxt.cs;
            avm_address    <= bus_nxt.addr;
            avm_writedata  <= bus_nxt.data;
        end
    end

endmodule

// File: tb/tb_game_tick_sequencer.sv
// tb_game_tick_sequencer
// Scoreboard bench for game_tick_sequencer: stimulus pushes expected bus
// writes and tick counts into queues; a negedge monitor pops and compares
// whenever the DUT completes a write or pulses tick. A small timer model
// raises timer_irq periodically and clears it on a status write.
module tb_game_tick_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [31:0] period_in;
    logic        timer_irq;
    logic        avm_waitrequest;
    logic [3:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [15:0] avm_writedata;
    logic        tick;
    logic [15:0] tick_count;
    logic        running;
    logic        busy;

    always #5 clk = ~clk;

    game_tick_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .stop            (stop),
        .period_in       (period_in),
        .timer_irq       (timer_irq),
        .avm_waitrequest (avm_waitrequest),
        .avm_address     (avm_address),
        .avm_chipselect  (avm_chipselect),
        .avm_write_n     (avm_write_n),
        .avm_writedata   (avm_writedata),
        .tick            (tick),
        .tick_count      (tick_count),
        .running         (running),
        .busy            (busy)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        int          cycles;
    } wr_t;

    wr_t         exp_wr[$];
    logic [15:0] exp_tick[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          tmr_period = 0;
    logic        running_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_wr(input logic [3:0] a, input logic [15:0] d, input int c);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.cycles = c;
        exp_wr.push_back(w);
    endtask

    task automatic push_start_seq(input logic [15:0] lo, input logic [15:0] hi, input int p1_cycles);
        push_wr(4'd2, lo, 1);
        push_wr(4'd3, hi, p1_cycles);
        push_wr(4'd4, 16'h0000, 1);
        push_wr(4'd5, 16'h0000, 1);
        push_wr(4'd1, 16'h0007, 1);
    endtask

    task automatic push_stop_seq();
        push_wr(4'd1, 16'h0008, 1);
        push_wr(4'd0, 16'h0000, 1);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] p);
        period_in = p;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        period_in = 32'hDEAD_BEEF;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 300) begin
            cyc(1);
            k++;
        end
        cyc(2);
        check(name, 32'(busy), 32'd0);
    endtask

    // Monitor: compare completed writes and ticks against the scoreboard
    initial begin
        int          hold;
        logic [3:0]  a0;
        logic [15:0] d0;
        logic        last_clr;
        wr_t         w;
        logic [15:0] e;
        hold = 0;
        a0 = '0;
        d0 = '0;
        last_clr = 1'b0;
        forever begin
            @(negedge clk);
            if (running) running_seen = 1'b1;
            if (tick) begin
                check("tick_expected", 32'(exp_tick.size() != 0), 32'd1);
                if (exp_tick.size() != 0) begin
                    e = exp_tick.pop_front();
                    check("tick_count_at_tick", 32'(tick_count), 32'(e));
                    check("tick_after_status_clear", 32'(last_clr), 32'd1);
                end
                last_clr = 1'b0;
            end
            if (avm_chipselect && !avm_write_n) begin
                if (hold == 0) begin
                    a0 = avm_address;
                    d0 = avm_writedata;
                end
                hold++;
                if (!avm_waitrequest) begin
                    check("write_expected", 32'(exp_wr.size() != 0), 32'd1);
                    if (exp_wr.size() != 0) begin
                        w = exp_wr.pop_front();
                        check("wr_addr", 32'({a0, avm_address}), 32'({w.addr, w.addr}));
                        check("wr_data", {d0, avm_writedata}, {w.data, w.data});
                        check("wr_hold_cycles", 32'(hold), 32'(w.cycles));
                    end
                    last_clr = (avm_address == 4'd0);
                    hold = 0;
                end
            end
        end
    end

    // Timer model: irq every tmr_period cycles once started, cleared by a
    // status write, halted by a STOP control write
    initial begin
        logic clr_w;
        logic start_w;
        logic stop_w;
        logic en;
        int   cnt;
        timer_irq = 1'b0;
        en = 1'b0;
        cnt = 0;
        forever begin
            @(negedge clk);
            clr_w   = avm_chipselect && !avm_write_n && !avm_waitrequest && (avm_address == 4'd0);
            start_w = avm_chipselect && !avm_write_n && !avm_waitrequest &&
                      (avm_address == 4'd1) && (avm_writedata == 16'h0007);
            stop_w  = avm_chipselect && !avm_write_n && !avm_waitrequest &&
                      (avm_address == 4'd1) && (avm_writedata == 16'h0008);
            @(posedge clk);
            #1;
            if (clr_w) timer_irq = 1'b0;
            if (start_w) begin
                en = 1'b1;
                cnt = 0;
            end
            if (stop_w) en = 1'b0;
            if (en && tmr_period != 0) begin
                cnt++;
                if (cnt >= tmr_period) begin
                    cnt = 0;
                    timer_irq = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        reset = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        period_in = '0;
        avm_waitrequest = 1'b0;
        cyc(3);
        check("rst_chipselect", 32'(avm_chipselect), 32'd0);
        check("rst_write_n",    32'(avm_write_n),    32'd1);
        check("rst_address",    32'(avm_address),    32'd0);
        check("rst_writedata",  32'(avm_writedata),  32'd0);
        check("rst_tick",       32'(tick),           32'd0);
        check("rst_tick_count", 32'(tick_count),     32'd0);
        check("rst_running",    32'(running),        32'd0);
        check("rst_busy",       32'(busy),           32'd0);
        reset = 1'b0;
        cyc(2);

        // Basic start: period 99, running on the sixth cycle
        tmr_period = 0;
        push_start_seq(16'h0063, 16'h0000, 1);
        pulse_start(32'd99);
        check("busy_after_start", 32'(busy), 32'd1);
        cyc(4);
        check("running_before_ctrl_done", 32'(running), 32'd0);
        cyc(1);
        check("running_after_ctrl", 32'(running), 32'd1);
        check("idle_bus_in_run", 32'({avm_chipselect, avm_write_n, avm_address}), 32'h10);
        push_stop_seq();
        pulse_stop();
        wait_idle("idle_after_stop_t1");
        check("running_after_stop_t1", 32'(running), 32'd0);

        // Default period when period_in is zero
        push_start_seq(16'hC34F, 16'h0000, 1);
        pulse_start(32'd0);
        cyc(8);
        push_stop_seq();
        pulse_stop();
        wait_idle("idle_after_stop_t2");

        // Five serviced timeouts at 100 cycles each
        tmr_period = 100;
        push_start_seq(16'h0064, 16'h0000, 1);
        for (int i = 1; i <= 5; i++) begin
            push_wr(4'd0, 16'h0000, 1);
            exp_tick.push_back(16'(i));
        end
        pulse_start(32'd100);
        cyc(560);
        push_stop_seq();
        pulse_stop();
        wait_idle("idle_after_stop_t3");
        check("tick_count_five", 32'(tick_count), 32'd5);
        check("ticks_drained_t3", 32'(exp_tick.size()), 32'd0);

        // Stall three cycles during the second period write
        tmr_period = 0;
        push_start_seq(16'h2345, 16'h0001, 4);
        period_in = 32'h0001_2345;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
        avm_waitrequest = 1'b1;
        cyc(3);
        avm_waitrequest = 1'b0;
        cyc(6);
        check("running_after_stall", 32'(running), 32'd1);
        push_stop_seq();
        pulse_stop();
        wait_idle("idle_after_stop_t4");

        // Stop arriving during WR_P2: finish it, then stop and ack
        running_seen = 1'b0;
        push_wr(4'd2, 16'h0005, 1);
        push_wr(4'd3, 16'h00AB, 1);
        push_wr(4'd4, 16'h0000, 1);
        push_stop_seq();
        period_in = 32'h00AB_0005;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(2);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        wait_idle("idle_after_stop_t5");
        check("running_never_t5", 32'(running_seen), 32'd0);
        check("tick_count_t5", 32'(tick_count), 32'd0);

        // Counter wrap: preset near 0xFFFF, then three timeouts
        tmr_period = 30;
        push_start_seq(16'h001E, 16'h0000, 1);
        for (int i = 0; i < 3; i++) push_wr(4'd0, 16'h0000, 1);
        exp_tick.push_back(16'hFFFF);
        exp_tick.push_back(16'h0000);
        exp_tick.push_back(16'h0001);
        pulse_start(32'd30);
        cyc(8);
        @(negedge clk);
        force dut.tick_count = 16'hFFFE;
        @(negedge clk);
        release dut.tick_count;
        cyc(100);
        push_stop_seq();
        pulse_stop();
        wait_idle("idle_after_stop_t6");
        check("tick_count_wrapped", 32'(tick_count), 32'd1);

        // start and stop together in IDLE: nothing happens
        tmr_period = 0;
        period_in = 32'd5;
        start = 1'b1;
        stop = 1'b1;
        cyc(1);
        start = 1'b0;
        stop = 1'b0;
        cyc(10);
        check("start_stop_busy", 32'(busy), 32'd0);
        check("start_stop_chipselect", 32'(avm_chipselect), 32'd0);

        cyc(2);
        check("writes_drained", 32'(exp_wr.size()), 32'd0);
        check("ticks_drained", 32'(exp_tick.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
